alu_ctrl_pipe: RTL and testbench
================================

Name: alu_ctrl_pipe

Overview:
- Registered, handshaked execute-issue stage. Decodes opcode/f3/f7 into a 5-bit ALU/branch/MDU operation and selects both ALU operands (rs1/pc, rs2/imm/4).
- Presents the result to the execute unit through a valid/ready interface with a 2-entry skid buffer, so backpressure never forms a combinational ready path.
- Sits between the register-read stage and the ALU/MDU.

Parameters:
- XLEN, 32, datapath width of operands and immediate.
- EN_M, 1, 1 decodes the RV32M MUL/DIV/REM group; 0 flags it illegal.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- flush  in  1  drop all held and incoming instructions
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept; driven directly from a flop
- opcode  in  7  instruction opcode
- f3  in  3  funct3
- f7  in  7  funct7
- imm  in  XLEN  immediate, already sign-extended by the decoder
- pc  in  XLEN  instruction address
- rs1In  in  XLEN  register source 1
- rs2In  in  XLEN  register source 2
- out_valid  out  1  outputs valid
- out_ready  in  1  execute unit accepts
- d1In  out  XLEN  ALU operand A
- d2In  out  XLEN  ALU operand B
- alu_op  out  5  operation code
- is_branch  out  1  conditional branch op
- is_mdu  out  1  multiply/divide op
- illegal  out  1  instruction not decodable

Behaviour:
- alu_op encoding:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND
  - 10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 BLTU, 15 BGEU
  - 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU
  - 24 PASSB; all others unused.
- Decode by opcode:
  - R (0110011): f3 selects the op. f7=0100000 gives SUB (f3=0) or SRA (f3=5). f7=0000001 with EN_M gives 16+f3. Any other f7, or 0100000 with f3 not in {0,5}, is illegal. d1=rs1In, d2=rs2In.
  - I (0010011): f3 selects the op; no SUB. For f3=1, f7 must be 0000000. For f3=5, f7 is 0000000 (SRL) or 0100000 (SRA); anything else is illegal. d2=imm.
  - LOAD 0000011, STORE 0100011: ADD, d1=rs1In, d2=imm.
  - BRANCH 1100011: f3 {0,1,4,5,6,7} map to ops 10,11,12,13,14,15; f3 2 or 3 is illegal. d1=rs1In, d2=rs2In, is_branch=1.
  - LUI 0110111: PASSB, d1=0, d2=imm.
  - AUIPC 0010111: ADD, d1=pc, d2=imm.
  - JAL 1101111, JALR 1100111: ADD, d1=pc, d2=4 (link address).
  - Any other opcode is illegal.
- Illegal instructions still flow through as a normal entry, with illegal=1, alu_op=0, d1In=d2In=0, is_branch=is_mdu=0.
- Latency: an accepted input (in_valid and in_ready) appears on the outputs the next cycle when the pipe is empty.
- Outputs hold stable while out_valid=1 and out_ready=0.
- FSM with states EMPTY, ONE, TWO (skid full):
  - EMPTY: accept -> ONE.
  - ONE: accept without drain -> TWO, captured into the skid register. Drain without accept -> EMPTY. Accept and drain together -> ONE, new entry loaded into the output register.
  - TWO: in_ready=0. Drain -> ONE, skid register moves into the output register.
- in_ready = (state != TWO), registered.
- flush (synchronous): next state EMPTY, out_valid=0. Any input presented in the flush cycle is discarded.
- rst has priority over flush.
- Reset values: state EMPTY, out_valid=0, in_ready=1, d1In=d2In=0, alu_op=0, is_branch=is_mdu=illegal=0.
- Reset mid-transfer drops all held entries.
- Datapath registers are not cleared on drain, only the valid bit. Out-of-valid values are don't-care except after reset.

Test Plan:
- R-type opcode=0110011 f3=0 f7=0100000, rs1In=9, rs2In=4, out_ready=1 -> next cycle out_valid=1, alu_op=1, d1In=9, d2In=4, illegal=0.
- I-type f3=5 f7=0100000 imm=3 -> alu_op=7. Same with f7=0000001 -> illegal=1, alu_op=0, d1In=d2In=0.
- EN_M=1, R f3=4 f7=0000001 -> alu_op=20, is_mdu=1. EN_M=0 build, same input -> illegal=1.
- JAL with pc=0x100 -> d1In=0x100, d2In=4, alu_op=0. Branch f3=2 -> illegal=1. Branch f3=6 -> alu_op=14, is_branch=1.
- Hold out_ready=0, send A then B -> in_ready=0 after B. Assert out_ready -> A then B emitted in order, no loss or duplication, in_ready back to 1 the cycle after A drains.
- With two entries held, assert flush (or rst) with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed input never appears.

Source files
------------

// File: rtl/alu_ctrl_pipe_if.sv
// rtl/alu_ctrl_pipe_if.sv - issue-side and execute-side handshake bundle for alu_ctrl_pipe
interface alu_ctrl_pipe_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rs1In;
  logic [XLEN-1:0] rs2In;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] d1In;
  logic [XLEN-1:0] d2In;
  logic [4:0]      alu_op;
  logic            is_branch;
  logic            is_mdu;
  logic            illegal;

  modport master (
    output flush, in_valid, opcode, f3, f7, imm, pc, rs1In, rs2In, out_ready,
    input  in_ready, out_valid, d1In, d2In, alu_op, is_branch, is_mdu, illegal
  );

  modport slave (
    input  flush, in_valid, opcode, f3, f7, imm, pc, rs1In, rs2In, out_ready,
    output in_ready, out_valid, d1In, d2In, alu_op, is_branch, is_mdu, illegal
  );
endinterface

// File: rtl/alu_ctrl_pipe.sv
// rtl/alu_ctrl_pipe.sv - execute-issue stage: opcode decode, operand select, 2-entry skid output
module alu_ctrl_pipe #(
  parameter int XLEN = 32,
  parameter bit EN_M = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  alu_ctrl_pipe_if.slave pipe_if
);

  typedef struct packed {
    logic [XLEN-1:0] d1;
    logic [XLEN-1:0] d2;
    logic [4:0]      op;
    logic            br;
    logic            mdu;
    logic            ill;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  // funct3 to ALU op for the f7=0 register and immediate forms
  function automatic logic [4:0] base_op(input logic [2:0] f3);
    case (f3)
      3'd0:    base_op = 5'd0;
      3'd1:    base_op = 5'd2;
      3'd2:    base_op = 5'd3;
      3'd3:    base_op = 5'd4;
      3'd4:    base_op = 5'd5;
      3'd5:    base_op = 5'd6;
      3'd6:    base_op = 5'd8;
      default: base_op = 5'd9;
    endcase
  endfunction

  logic [4:0]      w_op;
  logic [XLEN-1:0] w_d1;
  logic [XLEN-1:0] w_d2;
  logic            w_br;
  logic            w_mdu;
  logic            w_ill;
  entry_t          w_new;

  always_comb begin
    w_op  = '0;
    w_d1  = '0;
    w_d2  = '0;
    w_br  = 1'b0;
    w_mdu = 1'b0;
    w_ill = 1'b0;
    case (pipe_if.opcode)
      7'b0110011: begin
        w_d1 = pipe_if.rs1In;
        w_d2 = pipe_if.rs2In;
        if (pipe_if.f7 == 7'b0000000) begin
          w_op = base_op(pipe_if.f3);
        end else if (pipe_if.f7 == 7'b0100000 && pipe_if.f3 == 3'd0) begin
          w_op = 5'd1;
        end else if (pipe_if.f7 == 7'b0100000 && pipe_if.f3 == 3'd5) begin
          w_op = 5'd7;
        end else if (pipe_if.f7 == 7'b0000001 && EN_M) begin
          w_op  = {2'b10, pipe_if.f3};
          w_mdu = 1'b1;
        end else begin
          w_ill = 1'b1;
        end
      end
      7'b0010011: begin
        w_d1 = pipe_if.rs1In;
        w_d2 = pipe_if.imm;
        w_op = base_op(pipe_if.f3);
        if (pipe_if.f3 == 3'd1 && pipe_if.f7 != 7'b0000000) begin
          w_ill = 1'b1;
        end else if (pipe_if.f3 == 3'd5) begin
          if (pipe_if.f7 == 7'b0100000) w_op = 5'd7;
          else if (pipe_if.f7 != 7'b0000000) w_ill = 1'b1;
        end
      end
      7'b0000011, 7'b0100011: begin
        w_d1 = pipe_if.rs1In;
        w_d2 = pipe_if.imm;
      end
      7'b1100011: begin
        w_d1 = pipe_if.rs1In;
        w_d2 = pipe_if.rs2In;
        w_br = 1'b1;
        case (pipe_if.f3)
          3'd0:    w_op = 5'd10;
          3'd1:    w_op = 5'd11;
          3'd4:    w_op = 5'd12;
          3'd5:    w_op = 5'd13;
          3'd6:    w_op = 5'd14;
          3'd7:    w_op = 5'd15;
          default: w_ill = 1'b1;
        endcase
      end
      7'b0110111: begin
        w_op = 5'd24;
        w_d2 = pipe_if.imm;
      end
      7'b0010111: begin
        w_d1 = pipe_if.pc;
        w_d2 = pipe_if.imm;
      end
      7'b1101111, 7'b1100111: begin
        w_d1 = pipe_if.pc;
        w_d2 = XLEN'(4);
      end
      default: w_ill = 1'b1;
    endcase

    // an undecodable instruction travels as a zeroed entry with only the illegal bit set
    w_new = '0;
    if (w_ill) w_new.ill = 1'b1;
    else       w_new = '{d1: w_d1, d2: w_d2, op: w_op, br: w_br, mdu: w_mdu, ill: 1'b0};
  end

  state_t r_state;
  entry_t r_out;
  entry_t r_skid;
  logic   r_out_valid;
  logic   r_in_ready;
  logic   w_accept;
  logic   w_drain;

  assign w_accept = pipe_if.in_valid & r_in_ready;
  assign w_drain  = r_out_valid & pipe_if.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_out       <= '0;
      r_skid      <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else if (pipe_if.flush) begin
      r_state     <= EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            r_out       <= w_new;
            r_out_valid <= 1'b1;
            r_state     <= ONE;
          end
        end
        ONE: begin
          if (w_accept && !w_drain) begin
            r_skid     <= w_new;
            r_in_ready <= 1'b0;
            r_state    <= TWO;
          end else if (w_accept && w_drain) begin
            r_out <= w_new;
          end else if (w_drain) begin
            r_out_valid <= 1'b0;
            r_state     <= EMPTY;
          end
        end
        TWO: begin
          if (w_drain) begin
            r_out      <= r_skid;
            r_in_ready <= 1'b1;
            r_state    <= ONE;
          end
        end
        default: begin
          r_state     <= EMPTY;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign pipe_if.in_ready  = r_in_ready;
  assign pipe_if.out_valid = r_out_valid;
  assign pipe_if.d1In      = r_out.d1;
  assign pipe_if.d2In      = r_out.d2;
  assign pipe_if.alu_op    = r_out.op;
  assign pipe_if.is_branch = r_out.br;
  assign pipe_if.is_mdu    = r_out.mdu;
  assign pipe_if.illegal   = r_out.ill;

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// tb/tb_alu_ctrl_pipe.sv - directed checks of decode, operand select, skid ordering, flush and reset
module tb_alu_ctrl_pipe;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  alu_ctrl_pipe_if #(.XLEN(32)) bus1 ();
  alu_ctrl_pipe_if #(.XLEN(32)) bus0 ();

  alu_ctrl_pipe #(.XLEN(32), .EN_M(1'b1)) u_dut_m  (.clk(clk), .rst(rst), .pipe_if(bus1));
  alu_ctrl_pipe #(.XLEN(32), .EN_M(1'b0)) u_dut_nm (.clk(clk), .rst(rst), .pipe_if(bus0));

  assign bus0.flush     = bus1.flush;
  assign bus0.in_valid  = bus1.in_valid;
  assign bus0.opcode    = bus1.opcode;
  assign bus0.f3        = bus1.f3;
  assign bus0.f7        = bus1.f7;
  assign bus0.imm       = bus1.imm;
  assign bus0.pc        = bus1.pc;
  assign bus0.rs1In     = bus1.rs1In;
  assign bus0.rs2In     = bus1.rs2In;
  assign bus0.out_ready = bus1.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] imm, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    bus1.in_valid = 1'b1;
    bus1.opcode   = op;
    bus1.f3       = f3;
    bus1.f7       = f7;
    bus1.imm      = imm;
    bus1.pc       = pc;
    bus1.rs1In    = rs1;
    bus1.rs2In    = rs2;
  endtask

  // present one instruction for one edge with the execute side draining
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] imm, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    bus1.out_ready = 1'b1;
    drive(op, f3, f7, imm, pc, rs1, rs2);
    step();
    bus1.in_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus1.flush = 1'b0;
    bus1.out_ready = 1'b0;
    drive(7'h00, 3'd0, 7'h00, 32'h0, 32'h0, 32'h0, 32'h0);
    bus1.in_valid = 1'b0;
    step();
    step();

    check("rst_out_valid", 32'(bus1.out_valid), 32'd0);
    check("rst_in_ready",  32'(bus1.in_ready),  32'd1);
    check("rst_d1",        bus1.d1In,           32'd0);
    check("rst_d2",        bus1.d2In,           32'd0);
    check("rst_op",        32'(bus1.alu_op),    32'd0);
    check("rst_flags",     {29'd0, bus1.is_branch, bus1.is_mdu, bus1.illegal}, 32'd0);
    rst = 1'b0;
    step();

    issue(7'b0110011, 3'd0, 7'b0100000, 32'h0, 32'h0, 32'd9, 32'd4);
    check("sub_valid", 32'(bus1.out_valid), 32'd1);
    check("sub_op",    32'(bus1.alu_op),    32'd1);
    check("sub_d1",    bus1.d1In,           32'd9);
    check("sub_d2",    bus1.d2In,           32'd4);
    check("sub_ill",   32'(bus1.illegal),   32'd0);

    issue(7'b0010011, 3'd5, 7'b0100000, 32'd3, 32'h0, 32'h55, 32'h66);
    check("srai_op", 32'(bus1.alu_op), 32'd7);
    check("srai_d1", bus1.d1In,        32'h55);
    check("srai_d2", bus1.d2In,        32'd3);

    issue(7'b0010011, 3'd5, 7'b0000001, 32'd3, 32'h0, 32'h55, 32'h66);
    check("srai_bad_ill", 32'(bus1.illegal), 32'd1);
    check("srai_bad_op",  32'(bus1.alu_op),  32'd0);
    check("srai_bad_d1",  bus1.d1In,         32'd0);
    check("srai_bad_d2",  bus1.d2In,         32'd0);

    issue(7'b0110011, 3'd4, 7'b0000001, 32'h0, 32'h0, 32'd100, 32'd7);
    check("div_op",      32'(bus1.alu_op),  32'd20);
    check("div_mdu",     32'(bus1.is_mdu),  32'd1);
    check("div_ill",     32'(bus1.illegal), 32'd0);
    check("nom_div_ill", 32'(bus0.illegal), 32'd1);
    check("nom_div_op",  32'(bus0.alu_op),  32'd0);
    check("nom_div_mdu", 32'(bus0.is_mdu),  32'd0);

    issue(7'b1101111, 3'd0, 7'h00, 32'h800, 32'h100, 32'h11, 32'h22);
    check("jal_d1", bus1.d1In,        32'h100);
    check("jal_d2", bus1.d2In,        32'd4);
    check("jal_op", 32'(bus1.alu_op), 32'd0);

    issue(7'b1100011, 3'd2, 7'h00, 32'h0, 32'h0, 32'h11, 32'h22);
    check("br_f3_2_ill", 32'(bus1.illegal),   32'd1);
    check("br_f3_2_br",  32'(bus1.is_branch), 32'd0);

    issue(7'b1100011, 3'd6, 7'h00, 32'h0, 32'h0, 32'h11, 32'h22);
    check("bltu_op", 32'(bus1.alu_op),    32'd14);
    check("bltu_br", 32'(bus1.is_branch), 32'd1);
    check("bltu_d1", bus1.d1In,           32'h11);
    check("bltu_d2", bus1.d2In,           32'h22);

    issue(7'b0110111, 3'd0, 7'h00, 32'h12345000, 32'h40, 32'h7, 32'h8);
    check("lui_op", 32'(bus1.alu_op), 32'd24);
    check("lui_d1", bus1.d1In,        32'd0);
    check("lui_d2", bus1.d2In,        32'h12345000);

    issue(7'b0000011, 3'd2, 7'h00, 32'hFFFF_FFF0, 32'h0, 32'h200, 32'h0);
    check("ld_op", 32'(bus1.alu_op), 32'd0);
    check("ld_d2", bus1.d2In,        32'hFFFF_FFF0);

    // back-to-back with simultaneous accept and drain in ONE
    issue(7'b0110011, 3'd7, 7'h00, 32'h0, 32'h0, 32'hE0, 32'h1);
    issue(7'b0110011, 3'd6, 7'h00, 32'h0, 32'h0, 32'hF0, 32'h1);
    check("b2b_op",    32'(bus1.alu_op),    32'd8);
    check("b2b_d1",    bus1.d1In,           32'hF0);
    check("b2b_valid", 32'(bus1.out_valid), 32'd1);
    step();
    check("b2b_empty", 32'(bus1.out_valid), 32'd0);

    // skid: stall, fill both entries, offer a third that must be refused
    bus1.out_ready = 1'b0;
    drive(7'b0110011, 3'd0, 7'h00, 32'h0, 32'h0, 32'hA1, 32'h1);
    step();
    check("skid_a_valid", 32'(bus1.out_valid), 32'd1);
    check("skid_a_rdy",   32'(bus1.in_ready),  32'd1);
    drive(7'b0110011, 3'd0, 7'h00, 32'h0, 32'h0, 32'hB2, 32'h1);
    step();
    check("skid_full_rdy", 32'(bus1.in_ready), 32'd0);
    check("skid_hold_a",   bus1.d1In,          32'hA1);
    drive(7'b0110011, 3'd0, 7'h00, 32'h0, 32'h0, 32'hC3, 32'h1);
    step();
    check("skid_hold_a2",  bus1.d1In,          32'hA1);
    check("skid_full_rdy2", 32'(bus1.in_ready), 32'd0);
    bus1.in_valid  = 1'b0;
    bus1.out_ready = 1'b1;
    step();
    check("skid_b_out",   bus1.d1In,           32'hB2);
    check("skid_b_valid", 32'(bus1.out_valid), 32'd1);
    check("skid_b_rdy",   32'(bus1.in_ready),  32'd1);
    step();
    check("skid_drained", 32'(bus1.out_valid), 32'd0);
    step();
    check("skid_no_c",    32'(bus1.out_valid), 32'd0);

    // flush with two entries held and a live input
    bus1.out_ready = 1'b0;
    drive(7'b0110011, 3'd0, 7'h00, 32'h0, 32'h0, 32'h10, 32'h1);
    step();
    drive(7'b0110011, 3'd0, 7'h00, 32'h0, 32'h0, 32'h20, 32'h1);
    step();
    check("fl_full", 32'(bus1.in_ready), 32'd0);
    drive(7'b0110011, 3'd0, 7'h00, 32'h0, 32'h0, 32'h99, 32'h1);
    bus1.flush = 1'b1;
    step();
    bus1.flush    = 1'b0;
    bus1.in_valid = 1'b0;
    check("fl_valid", 32'(bus1.out_valid), 32'd0);
    check("fl_rdy",   32'(bus1.in_ready),  32'd1);
    bus1.out_ready = 1'b1;
    step();
    check("fl_no_d", 32'(bus1.out_valid), 32'd0);

    // reset with two entries held and a live input
    bus1.out_ready = 1'b0;
    drive(7'b0110011, 3'd0, 7'h00, 32'h0, 32'h0, 32'h30, 32'h1);
    step();
    drive(7'b0110011, 3'd0, 7'h00, 32'h0, 32'h0, 32'h40, 32'h1);
    step();
    check("rs_full", 32'(bus1.in_ready), 32'd0);
    drive(7'b0110011, 3'd0, 7'h00, 32'h0, 32'h0, 32'h88, 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus1.in_valid = 1'b0;
    check("rs_valid", 32'(bus1.out_valid), 32'd0);
    check("rs_rdy",   32'(bus1.in_ready),  32'd1);
    check("rs_d1",    bus1.d1In,           32'd0);
    bus1.out_ready = 1'b1;
    step();
    check("rs_no_in", 32'(bus1.out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
